// File: rtl/out_display_pkg.sv
// Shared types and constants for the out_display block: converter FSM
// states, datapath widths and the seven-segment glyph table.
package out_display_pkg;

    localparam int BCD_W   = 12;
    localparam int SHIFT_W = 20;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Glyph for a BCD digit; non-decimal codes show nothing
    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment decoder with a blanking override.
module seg7_decode
    import out_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] segments
);

    // Blanking takes priority over the glyph lookup
    always_comb begin
        segments = blank ? SEG_BLANK : seg_lookup(nibble);
    end

endmodule

// File: rtl/out_display.sv
// CPU output-port consumer: one-deep capture buffer with sticky overrun,
// sequential double-dabble binary-to-BCD converter, and a multiplexed
// 3-digit seven-segment display with leading-zero blanking.
module out_display
    import out_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out_valid,
    input  logic [7:0]       out_data,
    output logic [BCD_W-1:0] value_bcd,
    output logic [2:0]       digit_sel,
    output logic [6:0]       segments,
    output logic             busy,
    output logic             overrun
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    conv_state_e        state_q, state_d;
    logic [7:0]         pending_q, pending_d;
    logic               pending_full_q, pending_full_d;
    logic               overrun_q, overrun_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BCD_W-1:0]   value_bcd_q, value_bcd_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [1:0]         index_q, index_d;

    logic               consume;
    logic [SHIFT_W-1:0] adjusted;
    logic [3:0]         sel_nibble;
    logic               sel_blank;

    // The converter takes the buffered byte whenever it is idle
    assign consume = (state_q == ST_IDLE) && pending_full_q;

    // Capture buffer: newest byte wins; losing an unconsumed byte is sticky
    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        overrun_d      = overrun_q;
        if (out_valid) begin
            pending_d      = out_data;
            pending_full_d = 1'b1;
            if (pending_full_q && !consume) begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            pending_full_d = 1'b0;
        end
    end

    // Add-3 correction on each BCD nibble before the shift
    always_comb begin
        adjusted = shift_q;
        for (int i = 0; i < 3; i++) begin
            if (shift_q[8 + 4*i +: 4] >= 4'd5) begin
                adjusted[8 + 4*i +: 4] = shift_q[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter next state: load, eight shifts, then publish the BCD field
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        value_bcd_d = value_bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_full_q) begin
                    shift_d = {12'b0, pending_q};
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = {adjusted[SHIFT_W-2:0], 1'b0};
                count_d = count_q + 4'd1;
                if (count_q == 4'd7) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                value_bcd_d = shift_q[SHIFT_W-1:8];
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Refresh divider: each digit stays lit for REFRESH_DIV cycles
    always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        index_d   = index_q;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            index_d   = (index_q == 2'd2) ? 2'd0 : index_q + 2'd1;
        end
    end

    // All state registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            overrun_q      <= 1'b0;
            shift_q        <= '0;
            count_q        <= '0;
            value_bcd_q    <= '0;
            ref_cnt_q      <= '0;
            index_q        <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            overrun_q      <= overrun_d;
            shift_q        <= shift_d;
            count_q        <= count_d;
            value_bcd_q    <= value_bcd_d;
            ref_cnt_q      <= ref_cnt_d;
            index_q        <= index_d;
        end
    end

    // Digit mux with leading-zero blanking on hundreds and tens
    always_comb begin
        sel_nibble = value_bcd_q[3:0];
        sel_blank  = 1'b0;
        case (index_q)
            2'd1: begin
                sel_nibble = value_bcd_q[7:4];
                sel_blank  = (value_bcd_q[11:8] == 4'd0) && (value_bcd_q[7:4] == 4'd0);
            end
            2'd2: begin
                sel_nibble = value_bcd_q[11:8];
                sel_blank  = (value_bcd_q[11:8] == 4'd0);
            end
            default: begin
                sel_nibble = value_bcd_q[3:0];
                sel_blank  = 1'b0;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .nibble   (sel_nibble),
        .blank    (sel_blank),
        .segments (segments)
    );

    assign value_bcd = value_bcd_q;
    assign digit_sel = 3'b001 << index_q;
    assign busy      = (state_q != ST_IDLE) || pending_full_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/out_display.md
# out_display

Output-port consumer for the nic8 core. Sits directly downstream of the CPU's output register: it captures every byte the CPU emits on an `out` instruction and converts it to three decimal digits with a sequential double-dabble converter. It then drives a time-multiplexed 3-digit seven-segment display. It has a one-deep capture buffer and a sticky overrun flag, so back-to-back `out` instructions never stall the CPU.

## Interface
Parameters:
- `REFRESH_DIV`, 1024: clock cycles each digit stays lit; legal range 2..65536.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `out_valid`  in  1  CPU output strobe (CPU doOut); sampled each posedge.
- `out_data`  in  8  byte being output; sampled with `out_valid`.
- `value_bcd`  out  12  last fully converted value, {hundreds, tens, units}.
- `digit_sel`  out  3  one-hot digit enable, active-high; bit0 = units.
- `segments`  out  7  {g,f,e,d,c,b,a}, active-high.
- `busy`  out  1  conversion in progress or pending buffer full.
- `overrun`  out  1  sticky; a pending byte was overwritten before conversion.

## Operation
- **Capture:** on a posedge with `out_valid`=1, `out_data` is written to `pending` and `pending_full` is set.
  - If `pending_full` is already set and the converter is not consuming it this edge, the old byte is lost. The newest byte wins and `overrun` is set.
- **Converter FSM states:** IDLE, SHIFT, COMMIT.
  - IDLE: if `pending_full`, load shift register {12'b0, `pending`}, clear `pending_full`, set shift count to 0, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift the 20-bit register left by 1. After the 8th shift, go to COMMIT.
  - COMMIT: `value_bcd` takes the BCD field and the FSM returns to IDLE.
- **Simultaneous capture and consume:** if IDLE consumes `pending` on the same edge that `out_valid`=1, the new byte lands in `pending` with `pending_full`=1. No overrun is flagged.
- **Busy:** `busy` = (state≠IDLE) | `pending_full`.
- **Refresh counter:** counts 0..`REFRESH_DIV`-1. On wrap, the digit index advances 0→1→2→0.
  - `digit_sel` = 1<<index.
- **Segment decode:** combinational from the selected nibble of `value_bcd`, in hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- **Leading-zero blanking:** `segments`=0 on hundreds when hundreds=0. Same on tens when hundreds=0 and tens=0. Units are never blanked.

## Timing
- **Reset values:**
  - state IDLE, `pending_full`=0, `value_bcd`=000, `overrun`=0.
  - Refresh counter 0, index 0, so `digit_sel`=001 and `segments`=3F.
  - `busy`=0.
- **Reset mid-conversion:** the conversion is aborted and the pending byte is discarded. `value_bcd` returns to 000.
- **Latency:** capture edge E. Load at E+1. Shifts at E+2..E+9. COMMIT writes `value_bcd` at E+10.
  - `busy` is high from after E until after E+10.
  - Sustained throughput is one byte per 10 cycles.
- **Display timing:** `segments` and `digit_sel` change only on a refresh wrap or on a `value_bcd` update. The new value appears on the currently selected digit in the same cycle it commits.
- **Overrun:** cleared only by `reset`.

## Structure
- **Package `out_display_pkg`:**
  - FSM state enum.
  - Seven-segment constant table for 0..9 and BLANK=7'h00.
  - Widths: BCD 12, shift register 20, shift count 4.
- **Sub-module `seg7_decode`:** purely combinational.
  - Inputs: 4-bit nibble and `blank`. Output: 7-bit `segments`.
  - Instantiated once, after the digit mux.
- Refresh counter, capture buffer and converter FSM live in `out_display`.

## Test plan
- Reset, then idle 3 cycles → `value_bcd`=000, `digit_sel`=001, `segments`=3F, `busy`=0, `overrun`=0.
- Single pulse `out_data`=8'd255 at edge E → `busy` high E+1..E+10; `value_bcd`=12'h255 after E+10 and not earlier.
- `out_data`=8'd7, `REFRESH_DIV`=4, scan 12 cycles → units digit shows 07; tens and hundreds digits show 00; `digit_sel` sequence 001,010,100 every 4 cycles.
- Back-to-back bytes 8'd13, 8'd21, 8'd34 on consecutive edges:
  - 13 converts; 21 is overwritten by 34 → `overrun`=1.
  - `value_bcd` ends at 034.
  - Total bytes committed: two (13 and 34).
- Byte 8'd100, then 8'd200 exactly on the edge IDLE consumes 100 → `overrun` stays 0; `value_bcd`=100, then 200 ten cycles later.
- `reset` asserted during SHIFT of 8'd99 → after reset `value_bcd`=000 and `busy`=0; no later commit of 99.
